booth_multiplier: RTL and testbench
===================================

Name: booth_multiplier

Overview:
- Sequential radix-2 Booth multiplier; the multiply counterpart to the team's sequential non-restoring divider in the ALU datapath.
- Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product, one Booth step per clock.
- Has a start/busy/done handshake so the ALU sequencer drives the multiplier and the divider the same way.
- Supports signed (two's complement) and unsigned operands, selected per operation.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  request a multiply; sampled only when busy=0.
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when p is updated.
- p  output  2*WIDTH  product; holds until the next completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, p=0.
  - Internal A, Q, Q_1, M and count are cleared.
  - A reset mid-operation aborts it; no done pulse follows.
- Internal datapath width is E=WIDTH+1 bits:
  - M (multiplicand) = a extended to E bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - Q (multiplier) = b extended to E bits the same way.
  - Accumulator A is E bits; Q_1 is a 1-bit Booth history bit.
  - count is wide enough to hold E.
- States: IDLE, RUN, DONE.
- IDLE / DONE with start=1 (accept):
  - Load M, Q; A=0, Q_1=0, count=0.
  - Go to RUN; busy=1; done=0.
- IDLE / DONE with start=0:
  - Go to or stay in IDLE; done=0; p holds.
- RUN, each cycle (one Booth step):
  - {Q[0],Q_1}=01: A=A+M (mod 2^E).
  - {Q[0],Q_1}=10: A=A-M (mod 2^E).
  - 00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Q,Q_1} by 1; A's MSB is replicated.
  - count=count+1.
- RUN, on the step where count reaches E:
  - p = low 2*WIDTH bits of {A,Q} after the final shift.
  - Go to DONE; done=1; busy=0.
- DONE lasts exactly one cycle:
  - done=1 only in this cycle.
  - With start=0 it returns to IDLE.
  - With start=1 it accepts a new operation (back-to-back issue allowed).
- Latency: start accepted at edge 0; done and the new p are visible after edge E, i.e. 17 cycles for WIDTH=16.
- Throughput: one result every E+1 cycles when issued back-to-back.
- start while busy=1 is ignored; operands and signed_mode changing mid-operation have no effect.
- Product width rules:
  - The product is exact for all inputs in both modes, with no overflow.
  - Unsigned: p = a*b.
  - Signed: p = a*b as a 2*WIDTH-bit two's complement value.
  - The extra E bit ensures the unsigned most-negative/most-positive cases are correct.
- a=0 or b=0 still takes the full E cycles and yields p=0; there is no early termination.

Test Plan:
- Reset, then start with signed_mode=0, a=3, b=5 -> busy=1 for 17 cycles; done pulses once; p=0x0000000F; busy=0 with done.
- signed_mode=1, a=0xFFFD (-3), b=0x0005 -> p=0xFFFFFFF1; signed_mode=1, a=0x8000, b=0x8000 -> p=0x40000000.
- signed_mode=0, a=0xFFFF, b=0xFFFF -> p=0xFFFE0001; same operands with signed_mode=1 -> p=0x00000001.
- Start a=7, b=9; pulse start with a=2, b=2 at cycle 5 while busy -> second request ignored; p=0x0000003F; only one done pulse.
- Start a=0x1234, b=0x0100; drive rst=0 at cycle 8 -> busy=0, done=0, p=0 immediately; no done afterwards; a fresh start after reset completes correctly.
- Hold start=1 continuously with a=2, b=3, then a=4, b=5 in the DONE cycle -> results 6 then 20; done pulses 18 cycles apart.

Source files
------------

// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
//
// Sequential radix-2 Booth multiplier. Multiplies two WIDTH-bit operands into a
// 2*WIDTH-bit product, one Booth step per clock, using a WIDTH+1 bit internal
// datapath so that both unsigned and two's complement operands give an exact
// product. Uses the same start/busy/done handshake as the sequential divider.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   start        request a multiply; sampled only when busy=0
//   signed_mode  1 = two's complement operands, 0 = unsigned; sampled with start
//   a            multiplicand; sampled with start
//   b            multiplier; sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when p is updated
//   p            product; holds until the next completion
// -----------------------------------------------------------------------------
module booth_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    // One extra bit so the unsigned extremes survive the signed Booth recoding.
    localparam int unsigned E  = WIDTH + 1;
    localparam int unsigned CW = $clog2(E + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(E);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [E-1:0]         acc,   acc_n;
    logic [E-1:0]         q,     q_n;
    logic                 q1,    q1_n;
    logic [E-1:0]         m,     m_n;
    logic [CW-1:0]        count, count_n;
    logic [2*WIDTH-1:0]   p_reg, p_n;

    logic [E-1:0]         addsub;
    logic [E-1:0]         a_ext;
    logic [E-1:0]         b_ext;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            acc   <= '0;
            q     <= '0;
            q1    <= 1'b0;
            m     <= '0;
            count <= '0;
            p_reg <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            q     <= q_n;
            q1    <= q1_n;
            m     <= m_n;
            count <= count_n;
            p_reg <= p_n;
        end
    end

    // -------------------------------------------------------------------------
    // Operand extension to the internal width
    // -------------------------------------------------------------------------
    always_comb begin
        a_ext = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
        b_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
    end

    // -------------------------------------------------------------------------
    // Booth recoding of the current multiplier bit pair
    // -------------------------------------------------------------------------
    always_comb begin
        addsub = acc;
        unique case ({q[0], q1})
            2'b01:   addsub = acc + m;
            2'b10:   addsub = acc - m;
            default: addsub = acc;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state;
        acc_n   = acc;
        q_n     = q;
        q1_n    = q1;
        m_n     = m;
        count_n = count;
        p_n     = p_reg;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_n     = a_ext;
                    q_n     = b_ext;
                    acc_n   = '0;
                    q1_n    = 1'b0;
                    count_n = '0;
                    state_n = S_RUN;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_RUN: begin
                // Arithmetic shift right of {A,Q,Q_1}, applied to the
                // post-add accumulator so add and shift share one cycle.
                acc_n   = {addsub[E-1], addsub[E-1:1]};
                q_n     = {addsub[0], q[E-1:1]};
                q1_n    = q[0];
                count_n = count + CW'(1);
                if (count_n == LAST_COUNT) begin
                    // Low 2*WIDTH bits of {A,Q}: all of Q plus the low
                    // WIDTH-1 bits of A.
                    p_n     = {acc_n[WIDTH-2:0], q_n};
                    state_n = S_DONE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        p    = p_reg;
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier
//
// Self-checking bench for booth_multiplier (WIDTH=16). Expected products come
// from plain integer multiplication of the sign- or zero-extended operands.
// -----------------------------------------------------------------------------
module tb_booth_multiplier;

    localparam int unsigned W   = 16;
    localparam int          LAT = W + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              signed_mode;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              busy;
    logic              done;
    logic [2*W-1:0]    p;

    int checks;
    int errors;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .p           (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product of the extended operands, truncated to 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input bit sm, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        longint px;
        longint py;
        longint r;
        logic [63:0] rv;
        if (sm) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'({48'd0, x});
            py = longint'({48'd0, y});
        end
        r  = px * py;
        rv = r;
        return rv[2*W-1:0];
    endfunction

    // Issues one operation and waits (bounded) for done. Operands are
    // scrambled right after acceptance; they must not affect the result.
    task automatic run_op(input bit sm, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cyc, output logic busy_at_done,
                          output logic [2*W-1:0] prod);
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sm;
        a           = x;
        b           = y;
        @(posedge clk);
        #1;
        start       = 1'b0;
        signed_mode = ~sm;
        a           = W'($urandom);
        b           = W'($urandom);
        lat      = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        busy_at_done = busy;
        prod         = p;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (p !== '0) begin errors++; $display("FAIL reset_p: got %h expected 0", p); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        bit             sm_t [5];
        logic [W-1:0]   a_t  [5];
        logic [W-1:0]   b_t  [5];
        logic [2*W-1:0] e_t  [5];
        int lat, bc;
        logic bad;
        logic [2*W-1:0] pr;
        sm_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        a_t  = '{16'h0003, 16'hFFFD, 16'h8000, 16'hFFFF, 16'hFFFF};
        b_t  = '{16'h0005, 16'h0005, 16'h8000, 16'hFFFF, 16'hFFFF};
        e_t  = '{32'h0000000F, 32'hFFFFFFF1, 32'h40000000, 32'hFFFE0001, 32'h00000001};
        for (int i = 0; i < 5; i++) begin
            run_op(sm_t[i], a_t[i], b_t[i], lat, bc, bad, pr);
            checks++;
            if (pr !== e_t[i])
                begin errors++; $display("FAIL directed_p[%0d]: got %h expected %h", i, pr, e_t[i]); end
            checks++;
            if (lat != LAT)
                begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++;
            if (bc != LAT)
                begin errors++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected %0d", i, bc, LAT); end
            checks++;
            if (bad !== 1'b0)
                begin errors++; $display("FAIL directed_busy_at_done[%0d]: got %b expected 0", i, bad); end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0)
                begin errors++; $display("FAIL directed_done_pulse[%0d]: got %b expected 0", i, done); end
            checks++;
            if (p !== e_t[i])
                begin errors++; $display("FAIL directed_p_hold[%0d]: got %h expected %h", i, p, e_t[i]); end
        end
    endtask

    task automatic test_ignore_busy();
        int pulses;
        int first_cyc;
        logic [2*W-1:0] pr;
        pulses    = 0;
        first_cyc = -1;
        pr        = '0;
        @(negedge clk);
        start       = 1'b1;
        signed_mode = 1'b0;
        a           = 16'd7;
        b           = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            start = (i == 4);
            if (i == 4) begin
                a = 16'd2;
                b = 16'd2;
            end
            if (done === 1'b1) begin
                pulses++;
                if (first_cyc < 0) begin
                    first_cyc = i;
                    pr        = p;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ignore_busy_pulses: got %0d expected 1", pulses); end
        checks++;
        if (pr !== 32'h0000003F) begin errors++; $display("FAIL ignore_busy_p: got %h expected 0000003f", pr); end
        checks++;
        if (first_cyc != LAT) begin errors++; $display("FAIL ignore_busy_latency: got %0d expected %0d", first_cyc, LAT); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat, bc;
        logic bad;
        logic [2*W-1:0] pr;
        pulses = 0;
        @(negedge clk);
        start       = 1'b1;
        signed_mode = 1'b0;
        a           = 16'h1234;
        b           = 16'h0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
        checks++;
        if (p !== '0) begin errors++; $display("FAIL abort_p: got %h expected 0", p); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        run_op(1'b0, 16'h1234, 16'h0100, lat, bc, bad, pr);
        checks++;
        if (pr !== 32'h00123400) begin errors++; $display("FAIL abort_restart_p: got %h expected 00123400", pr); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL abort_restart_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [2*W-1:0] p1, p2;
        t1 = -1;
        t2 = -1;
        p1 = '0;
        p2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start       = 1'b1;
        signed_mode = 1'b0;
        a           = 16'd2;
        b           = 16'd3;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = i;
                    p1 = p;
                    a  = 16'd4;
                    b  = 16'd5;
                end else if (t2 < 0) begin
                    t2    = i;
                    p2    = p;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (p1 !== 32'd6) begin errors++; $display("FAIL b2b_first_p: got %h expected 00000006", p1); end
        checks++;
        if (p2 !== 32'd20) begin errors++; $display("FAIL b2b_second_p: got %h expected 00000014", p2); end
        checks++;
        if (t1 != LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", t1, LAT); end
        checks++;
        if (t2 - t1 != LAT + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, LAT + 1); end
    endtask

    task automatic test_random();
        logic [W-1:0] corner [6];
        logic [W-1:0] x, y;
        bit sm;
        int lat, bc;
        logic bad;
        logic [2*W-1:0] pr, exp_p;
        corner = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8001};
        for (int i = 0; i < 40; i++) begin
            sm = bit'($urandom_range(0, 1));
            x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
            y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
            exp_p = ref_mul(sm, x, y);
            run_op(sm, x, y, lat, bc, bad, pr);
            checks++;
            if (pr !== exp_p)
                begin errors++; $display("FAIL random_p[%0d] sm=%0d a=%h b=%h: got %h expected %h", i, sm, x, y, pr, exp_p); end
            checks++;
            if (lat != LAT)
                begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
